// File: rtl/ls_mem_responder.sv
// Serialises load/store and instruction-fetch requests into byte accesses on a
// byte-wide synchronous RAM, returning little-endian assembled words.
module ls_mem_responder #(
    parameter int          ADDR_W = 32,
    parameter logic [2:0]  IF_LEN = 3'd3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ls_req_en,
    input  logic              ls_rw,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [2:0]        ls_len,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic              if_en,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din
);

    typedef enum logic [1:0] {IDLE, DRD, DWR, IRD} state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [1:0]        IF_LAST  = IF_LEN[1:0];

    state_t              state_reg, state_next;
    logic [1:0]          idx_reg, idx_next;
    logic [1:0]          last_reg, last_next;
    logic [1:0]          cidx_reg, cidx_next;
    logic                iss_reg, iss_next;
    logic                v1_reg, v1_next;
    logic [31:0]         acc_reg, acc_next;
    logic [31:0]         wdata_reg, wdata_next;

    logic                pend_v_reg, pend_v_next;
    logic                pend_rw_reg, pend_rw_next;
    logic [ADDR_W-1:0]   pend_addr_reg, pend_addr_next;
    logic [1:0]          pend_len_reg, pend_len_next;
    logic [31:0]         pend_wdata_reg, pend_wdata_next;

    logic [ADDR_W-1:0]   mem_a_reg, mem_a_next;
    logic                mem_wr_reg, mem_wr_next;
    logic [7:0]          mem_dout_reg, mem_dout_next;
    logic                ls_done_reg, ls_done_next;
    logic [31:0]         ls_rdata_reg, ls_rdata_next;
    logic                if_done_reg, if_done_next;
    logic [31:0]         if_rdata_reg, if_rdata_next;

    // Request selection in IDLE: pending slot, then LS, then fetch.
    logic                st_en;
    logic                st_rw;
    logic                st_fetch;
    logic [ADDR_W-1:0]   st_addr;
    logic [1:0]          st_len;
    logic [31:0]         st_wdata;

    logic [1:0]          idx_inc;
    logic [31:0]         acc_merged;
    logic                unused_len_msb;

    assign unused_len_msb = ls_len[2];
    assign idx_inc        = idx_reg + 2'd1;
    assign acc_merged     = acc_reg | ({24'b0, mem_din} << {cidx_reg, 3'b000});

    always_comb begin
        st_en    = 1'b0;
        st_rw    = 1'b0;
        st_fetch = 1'b0;
        st_addr  = ls_addr;
        st_len   = ls_len[1:0];
        st_wdata = ls_wdata;
        if (state_reg == IDLE) begin
            if (pend_v_reg) begin
                st_en    = 1'b1;
                st_rw    = pend_rw_reg;
                st_addr  = pend_addr_reg;
                st_len   = pend_len_reg;
                st_wdata = pend_wdata_reg;
            end else if (ls_req_en) begin
                st_en = 1'b1;
                st_rw = ls_rw;
            end else if (if_en) begin
                st_en    = 1'b1;
                st_fetch = 1'b1;
                st_addr  = if_addr;
                st_len   = IF_LAST;
                st_wdata = 32'b0;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        last_next       = last_reg;
        cidx_next       = cidx_reg;
        iss_next        = iss_reg;
        v1_next         = v1_reg;
        acc_next        = acc_reg;
        wdata_next      = wdata_reg;
        pend_v_next     = pend_v_reg;
        pend_rw_next    = pend_rw_reg;
        pend_addr_next  = pend_addr_reg;
        pend_len_next   = pend_len_reg;
        pend_wdata_next = pend_wdata_reg;
        mem_a_next      = mem_a_reg;
        mem_wr_next     = mem_wr_reg;
        mem_dout_next   = mem_dout_reg;
        ls_done_next    = 1'b0;
        ls_rdata_next   = ls_rdata_reg;
        if_done_next    = 1'b0;
        if_rdata_next   = if_rdata_reg;

        // An LS request arriving during a fetch waits in the pending slot.
        if (state_reg == IRD && ls_req_en && !pend_v_reg) begin
            pend_v_next     = 1'b1;
            pend_rw_next    = ls_rw;
            pend_addr_next  = ls_addr;
            pend_len_next   = ls_len[1:0];
            pend_wdata_next = ls_wdata;
        end

        case (state_reg)
            IDLE: begin
                if (st_en) begin
                    if (pend_v_reg) begin
                        pend_v_next = 1'b0;
                    end
                    idx_next   = 2'd0;
                    cidx_next  = 2'd0;
                    last_next  = st_len;
                    wdata_next = st_wdata;
                    mem_a_next = st_addr;
                    acc_next   = 32'b0;
                    v1_next    = 1'b0;
                    if (st_rw) begin
                        state_next    = DWR;
                        mem_wr_next   = 1'b1;
                        mem_dout_next = st_wdata[7:0];
                        iss_next      = 1'b0;
                    end else begin
                        state_next = st_fetch ? IRD : DRD;
                        iss_next   = 1'b1;
                    end
                end
            end

            DWR: begin
                if (idx_reg == last_reg) begin
                    mem_wr_next   = 1'b0;
                    ls_done_next  = 1'b1;
                    ls_rdata_next = 32'b0;
                    state_next    = IDLE;
                end else begin
                    idx_next      = idx_inc;
                    mem_a_next    = mem_a_reg + ADDR_ONE;
                    mem_dout_next = wdata_reg[{idx_inc, 3'b000} +: 8];
                end
            end

            DRD, IRD: begin
                if (iss_reg) begin
                    if (idx_reg == last_reg) begin
                        iss_next = 1'b0;
                    end else begin
                        idx_next   = idx_inc;
                        mem_a_next = mem_a_reg + ADDR_ONE;
                    end
                end
                // v1_reg marks a cycle in which mem_din carries byte cidx_reg.
                v1_next = iss_reg;
                if (v1_reg) begin
                    acc_next  = acc_merged;
                    cidx_next = cidx_reg + 2'd1;
                    if (cidx_reg == last_reg) begin
                        v1_next    = 1'b0;
                        state_next = IDLE;
                        if (state_reg == DRD) begin
                            ls_done_next  = 1'b1;
                            ls_rdata_next = acc_merged;
                        end else begin
                            if_done_next  = 1'b1;
                            if_rdata_next = acc_merged;
                        end
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            idx_reg        <= 2'd0;
            last_reg       <= 2'd0;
            cidx_reg       <= 2'd0;
            iss_reg        <= 1'b0;
            v1_reg         <= 1'b0;
            acc_reg        <= 32'b0;
            wdata_reg      <= 32'b0;
            pend_v_reg     <= 1'b0;
            pend_rw_reg    <= 1'b0;
            pend_addr_reg  <= '0;
            pend_len_reg   <= 2'd0;
            pend_wdata_reg <= 32'b0;
            mem_a_reg      <= '0;
            mem_wr_reg     <= 1'b0;
            mem_dout_reg   <= 8'b0;
            ls_done_reg    <= 1'b0;
            ls_rdata_reg   <= 32'b0;
            if_done_reg    <= 1'b0;
            if_rdata_reg   <= 32'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            last_reg       <= last_next;
            cidx_reg       <= cidx_next;
            iss_reg        <= iss_next;
            v1_reg         <= v1_next;
            acc_reg        <= acc_next;
            wdata_reg      <= wdata_next;
            pend_v_reg     <= pend_v_next;
            pend_rw_reg    <= pend_rw_next;
            pend_addr_reg  <= pend_addr_next;
            pend_len_reg   <= pend_len_next;
            pend_wdata_reg <= pend_wdata_next;
            mem_a_reg      <= mem_a_next;
            mem_wr_reg     <= mem_wr_next;
            mem_dout_reg   <= mem_dout_next;
            ls_done_reg    <= ls_done_next;
            ls_rdata_reg   <= ls_rdata_next;
            if_done_reg    <= if_done_next;
            if_rdata_reg   <= if_rdata_next;
        end
    end

    assign mem_a    = mem_a_reg;
    assign mem_wr   = mem_wr_reg;
    assign mem_dout = mem_dout_reg;
    assign ls_done  = ls_done_reg;
    assign ls_rdata = ls_rdata_reg;
    assign if_done  = if_done_reg;
    assign if_rdata = if_rdata_reg;

endmodule
